control_unit: RTL
=================

# control_unit

Multicycle Moore control FSM that drives every control line of the 32-bit MIPS-subset datapath in `cpu`; it is the producer end of the datapath's control interface. It consumes the opcode/funct fields from the instruction register and the ALU flags. It sequences fetch, decode, execute, memory and write-back, and it traps invalid opcodes and, optionally, arithmetic overflow.

## Interface
- No parameters.
- `clk`  in  1  datapath clock, rising edge.
- `reset`  in  1  asynchronous, active-low; while low, FSM held in RST.
- `opcode`  in  6  Instr31_26.
- `funct`  in  6  Instr15_0[5:0].
- `overflow`, `zero`  in  1 each  ALU flags Overflow_ULA, Zero_ULA.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemReadOrWrite` (1=write), `A_w`, `B_w`, `AluOutWrite`, `EPCWrite`, `RegDst` (1=rd), `MemToReg` (1=MDR), `AluSrcA` (0=PC, 1=A)  out  1 each.
- `IorD`  out  2  00 PC, 01 AluOut.
- `AluSrcB`  out  2  00 B, 01 const 4, 10 sext(imm), 11 sext(imm)<<2.
- `AluOp`  out  3  000 pass A, 001 add, 010 sub, 011 and.
- `PCSource`  out  3  000 ALU result, 001 AluOut, 010 jump target, 011 exception vector 0x000000FE.
- `state_o`  out  5  current state encoding, debug.

## Operation
- Supported: R-type add(0x20), sub(0x22), and(0x24); addi(0x08), lw(0x23), sw(0x2B), beq(0x04), bne(0x05), j(0x02). Any other opcode, or R-type with another funct, traps.
- Outputs are a pure function of state. Every control not listed for a state is 0.
- RST: all outputs 0. Next state is FETCH.
- FETCH: IorD=00, read, AluSrcA=0, AluSrcB=01, AluOp=001. Next is FETCH_WAIT.
- FETCH_WAIT: same ALU drive plus PCWrite=1, PCSource=000, IRWrite=1. Next is DECODE.
- DECODE: A_w, B_w; AluOut ← PC + (sext<<2) via AluSrcB=11, AluOp=001, AluOutWrite. Next state by opcode.
- EXEC_R: AluSrcA=1, AluSrcB=00, AluOp per funct, AluOutWrite. Next is WB_R.
- WB_R: RegDst=1, MemToReg=0, RegWrite. Next is FETCH.
- ADDI_EX: AluSrcA=1, AluSrcB=10, add, AluOutWrite. Next is ADDI_WB.
- ADDI_WB: RegDst=0, RegWrite. Next is FETCH.
- MEM_ADDR: A + sext, AluOutWrite. Next is LW_RD (lw) or SW_WR (sw).
- LW_RD: IorD=01. Next is LW_WAIT.
- LW_WAIT: IorD=01. Next is LW_WB.
- LW_WB: MemToReg=1, RegDst=0, RegWrite. Next is FETCH.
- SW_WR: IorD=01, MemReadOrWrite=1. Next is FETCH.
- BRANCH: AluSrcA=1, AluSrcB=00, sub, PCSource=001. PCWrite = zero for beq, !zero for bne. Next is FETCH.
- JUMP: PCSource=010, PCWrite. Next is FETCH.
- EXC_EPC: AluSrcA=0, AluSrcB=01, AluOp=010, EPCWrite, so EPC ← PC−4, the address of the faulting instruction. Next is EXC_PC.
- EXC_PC: PCSource=011, PCWrite. Next is FETCH.

## Timing
- State register is asynchronously cleared to RST when `reset` falls. Any in-flight instruction is abandoned. No register write is asserted while `reset`=0.
- First FETCH occurs on the first rising edge after `reset` rises.
- Latency in cycles, counting from FETCH through the last state:
  - R-type and addi: 5.
  - lw: 7.
  - sw: 5.
  - beq/bne and j: 4.
  - Trap from DECODE: 5.
- Overflow trap, when enabled: at the end of EXEC_R or ADDI_EX with `overflow`=1, next state is EXC_EPC instead of write-back. RegWrite never asserts for the overflowing instruction.
- `overflow` is sampled only in EXEC_R and ADDI_EX, and only for add/addi/sub. For and, `overflow` is ignored.
- Memory read data is valid two edges after the address state, which is why the WAIT states exist. MemReadOrWrite is a single-cycle pulse.

## Configuration
- `CTRL_OVF_EXC_EN` defined: overflow trap as described above.
- `CTRL_OVF_EXC_EN` undefined: `overflow` is ignored; EXEC_R/ADDI_EX always proceed to write-back (wrapped result written). Invalid-opcode trap is present in both builds.

## Structure
- Package `control_pkg` holds:
  - state enum (5-bit);
  - opcode and funct constants;
  - AluOp, AluSrcB, IorD and PCSource encodings.
- Sub-module `control_decode`: combinational opcode/funct → next-state-from-DECODE, plus R-type AluOp. The main module holds the state register and the output decode.

## Test plan
- Reset:
  - Stimulus: hold `reset`=0 three cycles, release.
  - Required: all outputs 0 during reset; `state_o`=FETCH after the first edge; PCWrite+IRWrite in the second cycle.
- add, no overflow:
  - Stimulus: add (opcode 0, funct 0x20), `overflow`=0.
  - Required: sequence FETCH, FETCH_WAIT, DECODE, EXEC_R, WB_R; AluOp=001 in EXEC_R; RegWrite with RegDst=1 exactly once.
- lw then sw:
  - Stimulus: lw (0x23) followed by sw (0x2B).
  - Required for lw: IorD=01 for 2 cycles, then RegWrite with MemToReg=1.
  - Required for sw: single MemReadOrWrite=1 cycle with IorD=01.
- beq/bne:
  - beq with `zero`=1: PCWrite=1 and PCSource=001 in BRANCH.
  - bne with `zero`=1: PCWrite=0 in BRANCH.
- Invalid opcode:
  - Stimulus: opcode 0x3F.
  - Required: DECODE → EXC_EPC (EPCWrite, AluOp=010) → EXC_PC (PCSource=011, PCWrite).
- Mid-instruction reset and overflow trap:
  - addi with `overflow`=1: EXC_EPC with `CTRL_OVF_EXC_EN` defined, ADDI_WB otherwise.
  - `reset` dropped in LW_WAIT: immediate RST with all outputs 0.

Source files
------------

// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : control_pkg
// Purpose  : Shared types and encodings for the multicycle MIPS-subset
//            control unit: the 5-bit state enum, opcode/funct constants,
//            datapath mux/ALU encodings, the control-word struct and a helper
//            that maps a state to its control word.
// Revision : 1.0 - initial release
// ============================================================================
package control_pkg;

  typedef enum logic [4:0] {
    ST_RST        = 5'd0,
    ST_FETCH      = 5'd1,
    ST_FETCH_WAIT = 5'd2,
    ST_DECODE     = 5'd3,
    ST_EXEC_R     = 5'd4,
    ST_WB_R       = 5'd5,
    ST_ADDI_EX    = 5'd6,
    ST_ADDI_WB    = 5'd7,
    ST_MEM_ADDR   = 5'd8,
    ST_LW_RD      = 5'd9,
    ST_LW_WAIT    = 5'd10,
    ST_LW_WB      = 5'd11,
    ST_SW_WR      = 5'd12,
    ST_BRANCH     = 5'd13,
    ST_JUMP       = 5'd14,
    ST_EXC_EPC    = 5'd15,
    ST_EXC_PC     = 5'd16
  } state_t;

  // Opcodes (Instr31_26)
  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_j     = 6'h02;

  // R-type funct codes
  localparam logic [5:0] c_fn_add = 6'h20;
  localparam logic [5:0] c_fn_sub = 6'h22;
  localparam logic [5:0] c_fn_and = 6'h24;

  // AluOp
  localparam logic [2:0] c_aluop_pass = 3'b000;
  localparam logic [2:0] c_aluop_add  = 3'b001;
  localparam logic [2:0] c_aluop_sub  = 3'b010;
  localparam logic [2:0] c_aluop_and  = 3'b011;

  // AluSrcB
  localparam logic [1:0] c_srcb_b       = 2'b00;
  localparam logic [1:0] c_srcb_four    = 2'b01;
  localparam logic [1:0] c_srcb_imm     = 2'b10;
  localparam logic [1:0] c_srcb_imm_sl2 = 2'b11;

  // IorD
  localparam logic [1:0] c_iord_pc     = 2'b00;
  localparam logic [1:0] c_iord_aluout = 2'b01;

  // PCSource
  localparam logic [2:0] c_pcsrc_alu    = 3'b000;
  localparam logic [2:0] c_pcsrc_aluout = 3'b001;
  localparam logic [2:0] c_pcsrc_jump   = 3'b010;
  localparam logic [2:0] c_pcsrc_exc    = 3'b011;

  typedef struct packed {
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       a_write;
    logic       b_write;
    logic       aluout_write;
    logic       epc_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] iord;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [2:0] pc_source;
  } ctrl_t;

  // Control word for a state. The conditional branch PCWrite depends on the
  // live zero flag and is therefore added outside this table.
  function automatic ctrl_t ctrl_for_state(input state_t s, input logic [2:0] r_type_op);
    ctrl_t ctl;
    ctl = '0;
    case (s)
      ST_FETCH: begin
        ctl.iord      = c_iord_pc;
        ctl.alu_src_b = c_srcb_four;
        ctl.alu_op    = c_aluop_add;
      end
      ST_FETCH_WAIT: begin
        ctl.alu_src_b = c_srcb_four;
        ctl.alu_op    = c_aluop_add;
        ctl.pc_write  = 1'b1;
        ctl.pc_source = c_pcsrc_alu;
        ctl.ir_write  = 1'b1;
      end
      ST_DECODE: begin
        ctl.a_write      = 1'b1;
        ctl.b_write      = 1'b1;
        ctl.alu_src_b    = c_srcb_imm_sl2;
        ctl.alu_op       = c_aluop_add;
        ctl.aluout_write = 1'b1;
      end
      ST_EXEC_R: begin
        ctl.alu_src_a    = 1'b1;
        ctl.alu_src_b    = c_srcb_b;
        ctl.alu_op       = r_type_op;
        ctl.aluout_write = 1'b1;
      end
      ST_WB_R: begin
        ctl.reg_dst   = 1'b1;
        ctl.reg_write = 1'b1;
      end
      ST_ADDI_EX, ST_MEM_ADDR: begin
        ctl.alu_src_a    = 1'b1;
        ctl.alu_src_b    = c_srcb_imm;
        ctl.alu_op       = c_aluop_add;
        ctl.aluout_write = 1'b1;
      end
      ST_ADDI_WB: begin
        ctl.reg_write = 1'b1;
      end
      ST_LW_RD, ST_LW_WAIT: begin
        ctl.iord = c_iord_aluout;
      end
      ST_LW_WB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
      end
      ST_SW_WR: begin
        ctl.iord      = c_iord_aluout;
        ctl.mem_write = 1'b1;
      end
      ST_BRANCH: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = c_srcb_b;
        ctl.alu_op    = c_aluop_sub;
        ctl.pc_source = c_pcsrc_aluout;
      end
      ST_JUMP: begin
        ctl.pc_source = c_pcsrc_jump;
        ctl.pc_write  = 1'b1;
      end
      ST_EXC_EPC: begin
        // PC already advanced by 4 in FETCH_WAIT; PC-4 points at the culprit.
        ctl.alu_src_b = c_srcb_four;
        ctl.alu_op    = c_aluop_sub;
        ctl.epc_write = 1'b1;
      end
      ST_EXC_PC: begin
        ctl.pc_source = c_pcsrc_exc;
        ctl.pc_write  = 1'b1;
      end
      default: ctl = '0;
    endcase
    return ctl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_decode.sv
`default_nettype none
// ============================================================================
// Module   : control_decode
// Purpose  : Combinational opcode/funct decode. Produces the state that
//            follows DECODE, the ALU operation for R-type execute, and whether
//            the instruction is subject to the overflow trap.
// Ports    : i_opcode [5:0]      instruction opcode
//            i_funct  [5:0]      R-type funct field
//            o_decode_next       next state out of DECODE (EXC_EPC if invalid)
//            o_r_type_op [2:0]   AluOp for EXEC_R
//            o_ovf_checked       1 for add/sub/addi
// Revision : 1.0 - initial release
// ============================================================================
module control_decode
  import control_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output state_t     o_decode_next,
  output logic [2:0] o_r_type_op,
  output logic       o_ovf_checked
);

  always_comb begin
    o_decode_next = ST_EXC_EPC;
    o_r_type_op   = c_aluop_add;
    o_ovf_checked = 1'b0;
    case (i_opcode)
      c_op_rtype: begin
        case (i_funct)
          c_fn_add: begin
            o_decode_next = ST_EXEC_R;
            o_r_type_op   = c_aluop_add;
            o_ovf_checked = 1'b1;
          end
          c_fn_sub: begin
            o_decode_next = ST_EXEC_R;
            o_r_type_op   = c_aluop_sub;
            o_ovf_checked = 1'b1;
          end
          c_fn_and: begin
            o_decode_next = ST_EXEC_R;
            o_r_type_op   = c_aluop_and;
          end
          default: o_decode_next = ST_EXC_EPC;
        endcase
      end
      c_op_addi: begin
        o_decode_next = ST_ADDI_EX;
        o_ovf_checked = 1'b1;
      end
      c_op_lw, c_op_sw:   o_decode_next = ST_MEM_ADDR;
      c_op_beq, c_op_bne: o_decode_next = ST_BRANCH;
      c_op_j:             o_decode_next = ST_JUMP;
      default:            o_decode_next = ST_EXC_EPC;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Purpose  : Multicycle Moore control FSM for the 32-bit MIPS-subset datapath.
//            Sequences fetch/decode/execute/memory/write-back and traps
//            invalid opcodes (and optionally arithmetic overflow) through
//            EXC_EPC -> EXC_PC.
// Config   : define CTRL_OVF_EXC_EN to trap add/sub/addi overflow; otherwise
//            overflow is ignored and the wrapped result is written back.
// Ports    : clk, reset (async, active-low)
//            opcode[5:0], funct[5:0], overflow, zero   - IR fields, ALU flags
//            PCWrite, IRWrite, RegWrite, MemReadOrWrite, A_w, B_w,
//            AluOutWrite, EPCWrite, RegDst, MemToReg, AluSrcA,
//            IorD[1:0], AluSrcB[1:0], AluOp[2:0], PCSource[2:0] - controls
//            state_o[4:0]                              - current state (debug)
// Revision : 1.0 - initial release
// ============================================================================
module control_unit
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       overflow,
  input  logic       zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemReadOrWrite,
  output logic       A_w,
  output logic       B_w,
  output logic       AluOutWrite,
  output logic       EPCWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       AluSrcA,
  output logic [1:0] IorD,
  output logic [1:0] AluSrcB,
  output logic [2:0] AluOp,
  output logic [2:0] PCSource,
  output logic [4:0] state_o
);

  state_t     r_state;
  ctrl_t      r_ctrl;
  state_t     w_next;
  state_t     w_decode_next;
  logic [2:0] w_r_type_op;
  logic       w_ovf_checked;
  logic       w_ovf_trap;
  logic       w_branch_taken;

  control_decode u_decode (
    .i_opcode      (opcode),
    .i_funct       (funct),
    .o_decode_next (w_decode_next),
    .o_r_type_op   (w_r_type_op),
    .o_ovf_checked (w_ovf_checked)
  );

`ifdef CTRL_OVF_EXC_EN
  assign w_ovf_trap = overflow & w_ovf_checked;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = overflow ^ w_ovf_checked;
  assign w_ovf_trap   = 1'b0;
`endif

  always_comb begin
    w_next = ST_RST;
    case (r_state)
      ST_RST:        w_next = ST_FETCH;
      ST_FETCH:      w_next = ST_FETCH_WAIT;
      ST_FETCH_WAIT: w_next = ST_DECODE;
      ST_DECODE:     w_next = w_decode_next;
      ST_EXEC_R:     w_next = w_ovf_trap ? ST_EXC_EPC : ST_WB_R;
      ST_ADDI_EX:    w_next = w_ovf_trap ? ST_EXC_EPC : ST_ADDI_WB;
      ST_MEM_ADDR:   w_next = (opcode == c_op_lw) ? ST_LW_RD : ST_SW_WR;
      ST_LW_RD:      w_next = ST_LW_WAIT;
      ST_LW_WAIT:    w_next = ST_LW_WB;
      ST_EXC_EPC:    w_next = ST_EXC_PC;
      ST_WB_R, ST_ADDI_WB, ST_LW_WB, ST_SW_WR,
      ST_BRANCH, ST_JUMP, ST_EXC_PC:
                     w_next = ST_FETCH;
      default:       w_next = ST_RST;
    endcase
  end

  // State and control word are registered together from the next state, so
  // the outputs are glitch-free and are cleared with the state on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_RST;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_for_state(w_next, w_r_type_op);
    end
  end

  // The branch outcome is the zero flag of the subtraction issued in BRANCH
  // itself, so it cannot be registered ahead of time.
  assign w_branch_taken = (opcode == c_op_bne) ? ~zero : zero;

  assign PCWrite        = r_ctrl.pc_write | ((r_state == ST_BRANCH) & w_branch_taken);
  assign IRWrite        = r_ctrl.ir_write;
  assign RegWrite       = r_ctrl.reg_write;
  assign MemReadOrWrite = r_ctrl.mem_write;
  assign A_w            = r_ctrl.a_write;
  assign B_w            = r_ctrl.b_write;
  assign AluOutWrite    = r_ctrl.aluout_write;
  assign EPCWrite       = r_ctrl.epc_write;
  assign RegDst         = r_ctrl.reg_dst;
  assign MemToReg       = r_ctrl.mem_to_reg;
  assign AluSrcA        = r_ctrl.alu_src_a;
  assign IorD           = r_ctrl.iord;
  assign AluSrcB        = r_ctrl.alu_src_b;
  assign AluOp          = r_ctrl.alu_op;
  assign PCSource       = r_ctrl.pc_source;
  assign state_o        = r_state;

endmodule
`default_nettype wire
